// File: rtl/spi_master.sv
// SPI initiator, mode 0, LSB first, one width-bit word per transaction.
// Define SPI_MASTER_LOOPBACK_EN to capture the internal mosi instead of the miso pin.
module spi_master #(
    parameter int width      = 8,
    parameter int halfPeriod = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] txData,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int phaseW = (halfPeriod > 1) ? $clog2(halfPeriod) : 1;
    localparam int bitW   = $clog2(width);
    localparam logic [phaseW-1:0] phaseLast = phaseW'(halfPeriod - 1);
    localparam logic [bitW-1:0]   bitLast   = bitW'(width - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } stateT;

    stateT             state, stateNext;
    logic [phaseW-1:0] phaseCnt, phaseNext;
    logic [bitW-1:0]   bitCnt, bitNext;
    logic [width-1:0]  txShift, txNext;
    logic [width-1:0]  rxShift, rxNext;
    logic [width-1:0]  rxDataNext;
    logic              csNext, sclkNext, mosiNext, busyNext, doneNext;
    logic              phaseEnd;
    logic              captureBit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unusedMiso;
    assign unusedMiso = miso;
    assign captureBit = mosi;
`else
    assign captureBit = miso;
`endif

    assign phaseEnd = (phaseCnt == phaseLast);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phaseCnt <= '0;
            bitCnt   <= '0;
            txShift  <= '0;
            rxShift  <= '0;
            rxData   <= '0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            phaseCnt <= phaseNext;
            bitCnt   <= bitNext;
            txShift  <= txNext;
            rxShift  <= rxNext;
            rxData   <= rxDataNext;
            cs       <= csNext;
            sclk     <= sclkNext;
            mosi     <= mosiNext;
            busy     <= busyNext;
            done     <= doneNext;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        stateNext  = state;
        phaseNext  = '0;
        bitNext    = bitCnt;
        txNext     = txShift;
        rxNext     = rxShift;
        rxDataNext = rxData;
        csNext     = cs;
        sclkNext   = sclk;
        mosiNext   = mosi;
        busyNext   = busy;
        doneNext   = 1'b0;

        // Every non-idle state lasts exactly halfPeriod cycles.
        if (state != IDLE && !phaseEnd) begin
            phaseNext = phaseCnt + phaseW'(1);
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    txNext    = txData;
                    csNext    = 1'b0;
                    busyNext  = 1'b1;
                    mosiNext  = txData[0];
                    bitNext   = '0;
                    stateNext = LEAD;
                end
            end
            LEAD: begin
                if (phaseEnd) begin
                    sclkNext  = 1'b1;
                    stateNext = HIGH;
                end
            end
            HIGH: begin
                if (phaseEnd) begin
                    // Sample at the end of the high phase, then shift out the next bit on the fall.
                    rxNext   = {captureBit, rxShift[width-1:1]};
                    sclkNext = 1'b0;
                    if (bitCnt == bitLast) begin
                        stateNext = TRAIL;
                    end else begin
                        txNext    = txShift >> 1;
                        mosiNext  = txShift[1];
                        bitNext   = bitCnt + bitW'(1);
                        stateNext = LOW;
                    end
                end
            end
            LOW: begin
                if (phaseEnd) begin
                    sclkNext  = 1'b1;
                    stateNext = HIGH;
                end
            end
            TRAIL: begin
                if (phaseEnd) begin
                    csNext     = 1'b1;
                    busyNext   = 1'b0;
                    mosiNext   = 1'b0;
                    rxDataNext = rxShift;
                    doneNext   = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator that pairs with the team's receiving `shiftregister` SPI peripheral. It generates `cs`, `sclk` and `mosi` and captures `miso`, moving one `width`-bit word per transaction, LSB first, matching the peripheral's right-shift order. It sits between host logic, which issues `start` with `txData`, and the off-block serial pins.

## Interface
- `width`, default 8: bits per transaction; must be ≥2.
- `halfPeriod`, default 4: `clk` cycles per `sclk` half-period; must be ≥1.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a transaction; sampled only in IDLE.
- `txData` in `width`: word to send; latched when `start` is accepted.
- `rxData` out `width`: last received word; updated only at transaction end.
- `busy` out 1: high from the `start`-accept edge until the `done` edge.
- `done` out 1: one-cycle pulse when `rxData` becomes valid.
- `cs` out 1: active-low chip select.
- `sclk` out 1: serial clock; idles low (mode 0).
- `mosi` out 1: serial data to the peripheral.
- `miso` in 1: serial data from the peripheral.

## Operation
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rxData`=0, state IDLE, internal shift registers and counters cleared.
- States: IDLE, LEAD, HIGH, LOW, TRAIL. A phase counter counts `halfPeriod` cycles in every non-IDLE state. A bit counter runs 0..`width`-1.
- IDLE, when `start`=1: latch `txData` into txShift; drive `cs`=0, `busy`=1, `mosi`=`txData`[0]; clear the bit counter; go to LEAD.
- LEAD, after `halfPeriod` cycles: drive `sclk`=1; go to HIGH.
- HIGH, after `halfPeriod` cycles:
  - Capture `miso` as the new rxShift MSB, shifting rxShift right.
  - Drive `sclk`=0.
  - If the bit counter = `width`-1, go to TRAIL.
  - Otherwise shift txShift right, drive `mosi` with the new txShift[0], increment the bit counter, and go to LOW.
- LOW, after `halfPeriod` cycles: drive `sclk`=1; go to HIGH.
- TRAIL, after `halfPeriod` cycles: drive `cs`=1, `busy`=0, `mosi`=0; load `rxData` from rxShift; pulse `done`; go to IDLE.
- Data ordering:
  - `mosi` changes only on `sclk` falling edges, or at `cs` assertion, and is stable for the whole high phase.
  - `miso` is sampled at the end of each high phase, so the peripheral has the full high phase to settle.
  - First bit on both lines is bit 0; after `width` bits, `rxData`[i] equals the i-th sampled bit.
- `start` outside IDLE is ignored. `txData` changes after acceptance have no effect.
- `start` held high in the cycle `done` is asserted starts the next transaction. In that case `cs` is high for exactly one cycle between transactions.
- Reset mid-transaction: all outputs return to their reset values immediately, without waiting for `clk`. No `done` pulse is produced and the partial word is discarded.

## Timing
- `start` accepted on edge T: `cs` falls and `mosi` is valid after edge T.
- k-th rising `sclk` edge (k=1..`width`) occurs after edge T + (2k-1)·`halfPeriod`.
- `done`=1, `cs`=1 and the new `rxData` all take effect after edge T + (2·`width`+1)·`halfPeriod`. With defaults this is T+68.
- `sclk` duty cycle is 50%; `sclk` period is 2·`halfPeriod` `clk` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined: the `miso` pin is ignored and the capture logic samples the internal `mosi` instead. After any transaction, `rxData` equals the latched `txData`.
- `SPI_MASTER_LOOPBACK_EN` undefined: capture samples the `miso` port as described above.

## Test plan
- Reset: assert `reset` asynchronously between `clk` edges -> `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rxData`=8'h00 immediately.
- Basic transfer: `txData`=8'hA5, peripheral model returns 8'h3C LSB first, defaults -> `mosi` at the 8 rising `sclk` edges reads 1,0,1,0,0,1,0,1; exactly 8 `sclk` pulses; `done` one cycle at T+68; `rxData`=8'h3C.
- Busy/back-to-back: `start` held high continuously -> second transaction begins the cycle after `done` with `cs` high for exactly 1 cycle; a `start` pulse mid-transfer produces no extra transaction.
- Reset mid-transfer: assert `reset` after the 3rd rising `sclk` -> outputs return to reset values at once, no `done`, `rxData`=8'h00. The next transfer of 8'hFF with `miso`=1 yields `rxData`=8'hFF.
- Parameters: `width`=4, `halfPeriod`=1, `txData`=4'h9, `miso` constant 0 -> `done` at T+9, `rxData`=4'h0, `mosi` bits 1,0,0,1.
- Loopback: with `SPI_MASTER_LOOPBACK_EN`, `txData`=8'h5A and `miso` forced 0 -> `rxData`=8'h5A. Without the macro, the same stimulus gives `rxData`=8'h00.
